// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared NoC definitions for the PE blocks. It holds the flit and credit field
// widths, the bit positions of the valid and tail flags, the arbiter state
// encoding, and pack/unpack helpers for the flit and credit formats.
//
// Flit format (MSB first):   {valid, tail, dest, vc, data}
// Credit format (MSB first): {valid, vc}
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int NOC_DEST_BITS  = 2;
    localparam int NOC_VC_BITS    = 1;
    localparam int NOC_DATA_WIDTH = 32;

    localparam int NOC_FLIT_WIDTH     = 2 + NOC_DEST_BITS + NOC_VC_BITS + NOC_DATA_WIDTH;
    localparam int NOC_FLIT_VALID_POS = NOC_FLIT_WIDTH - 1;
    localparam int NOC_FLIT_TAIL_POS  = NOC_FLIT_WIDTH - 2;

    localparam int NOC_CREDIT_WIDTH     = 1 + NOC_VC_BITS;
    localparam int NOC_CREDIT_VALID_POS = NOC_VC_BITS;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                      valid;
        logic                      tail;
        logic [NOC_DEST_BITS-1:0]  dest;
        logic [NOC_VC_BITS-1:0]    vc;
        logic [NOC_DATA_WIDTH-1:0] data;
    } flit_t;

    typedef struct packed {
        logic                   valid;
        logic [NOC_VC_BITS-1:0] vc;
    } credit_t;

    function automatic logic [NOC_FLIT_WIDTH-1:0] pack_flit(input flit_t f);
        return f;
    endfunction

    function automatic flit_t unpack_flit(input logic [NOC_FLIT_WIDTH-1:0] bits);
        return flit_t'(bits);
    endfunction

    function automatic logic [NOC_CREDIT_WIDTH-1:0] pack_credit(input credit_t c);
        return c;
    endfunction

    function automatic credit_t unpack_credit(input logic [NOC_CREDIT_WIDTH-1:0] bits);
        return credit_t'(bits);
    endfunction

    function automatic logic flit_is_valid(input logic [NOC_FLIT_WIDTH-1:0] bits);
        return bits[NOC_FLIT_VALID_POS];
    endfunction

    function automatic logic flit_is_tail(input logic [NOC_FLIT_WIDTH-1:0] bits);
        return bits[NOC_FLIT_TAIL_POS];
    endfunction

    function automatic logic credit_is_valid(input logic [NOC_CREDIT_WIDTH-1:0] bits);
        return bits[NOC_CREDIT_VALID_POS];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. It grants the first requester at
// or after ptr, wrapping around to index 0 when none is found above ptr.
//
// Ports:
//   req   [N-1:0]     request vector
//   ptr   [PTR_W-1:0] index with the highest priority this cycle
//   grant [N-1:0]     one-hot grant, or zero when nothing requests
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] upper_mask;
    logic [N-1:0] masked_req;

    // upper_mask keeps only requesters at positions >= ptr
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign upper_mask[gi] = (int'(ptr) <= gi);
    end

    assign masked_req = req & upper_mask;

    // x & (~x + 1) isolates the lowest set bit; fall back to the unmasked
    // vector when nothing at or above ptr requests (wrap-around).
    assign grant = (masked_req != '0) ? (masked_req & (~masked_req + ONE))
                                      : (req & (~req + ONE));

endmodule

// File: rtl/pe_inject_arbiter.sv
// -----------------------------------------------------------------------------
// pe_inject_arbiter
// Shares the PE's single NoC injection port among NUM_SRC local sources.
// Grants are round-robin and packet-atomic: a source that sends a non-tail
// flit owns the port until its tail flit. It also keeps one credit counter per
// VC, decremented on injection and incremented on credit return.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   global enable (credits are still counted when low)
//   src_valid/src_tail   per-source flit valid and last-flit flag
//   src_dest/src_vc      per-source destination and VC, source i in slice i
//   src_data             per-source payload
//   src_ready            one-hot or zero; transfer when valid & ready
//   flit_out             registered {valid, tail, dest, vc, data}
//   send_flit            valid bit of flit_out
//   credit_in            {valid, vc} credit return from the router
//   credit_err           sticky, set on a credit return beyond buffer depth
//
// Optional build macro PE_INJECT_STATS_EN adds per-source flit counters, a
// credit-stall counter and ports stat_sel, stat_flits, stat_stalls.
// -----------------------------------------------------------------------------
module pe_inject_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_SRC           = 4,
    parameter int NUM_VCS           = 2,
    parameter int FLIT_BUFFER_DEPTH = 8,
    parameter int FLIT_DATA_WIDTH   = NOC_DATA_WIDTH,
    parameter int DEST_BITS         = NOC_DEST_BITS,
    parameter int VC_BITS           = NOC_VC_BITS
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          en,
    input  logic [NUM_SRC-1:0]                            src_valid,
    input  logic [NUM_SRC-1:0]                            src_tail,
    input  logic [NUM_SRC*DEST_BITS-1:0]                  src_dest,
    input  logic [NUM_SRC*VC_BITS-1:0]                    src_vc,
    input  logic [NUM_SRC*FLIT_DATA_WIDTH-1:0]            src_data,
    output logic [NUM_SRC-1:0]                            src_ready,
    output logic [2+DEST_BITS+VC_BITS+FLIT_DATA_WIDTH-1:0] flit_out,
    output logic                                          send_flit,
    input  logic [VC_BITS:0]                              credit_in,
    output logic                                          credit_err
`ifdef PE_INJECT_STATS_EN
    ,
    input  logic [$clog2(NUM_SRC)-1:0]                    stat_sel,
    output logic [31:0]                                   stat_flits,
    output logic [31:0]                                   stat_stalls
`endif
);

    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W  = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam int FLIT_W = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLIT_BUFFER_DEPTH);

    // ---------------- per-source field views ----------------
    logic [DEST_BITS-1:0]       dest_arr [NUM_SRC];
    logic [VC_BITS-1:0]         vc_arr   [NUM_SRC];
    logic [FLIT_DATA_WIDTH-1:0] data_arr [NUM_SRC];
    logic [NUM_SRC-1:0]         eligible;

    logic [CNT_W-1:0] credit_cnt_reg  [NUM_VCS];
    logic [CNT_W-1:0] credit_cnt_next [NUM_VCS];

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign dest_arr[gi] = src_dest[gi*DEST_BITS +: DEST_BITS];
        assign vc_arr[gi]   = src_vc[gi*VC_BITS +: VC_BITS];
        assign data_arr[gi] = src_data[gi*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
        assign eligible[gi] = src_valid[gi] && (credit_cnt_reg[vc_arr[gi]] != '0);
    end

    // ---------------- arbitration ----------------
    arb_state_t       state_reg, state_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;

    logic [NUM_SRC-1:0] rr_grant;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   xfer_idx;
    logic               xfer;
    logic               xfer_tail;
    logic [VC_BITS-1:0] xfer_vc;

    rr_arbiter #(
        .N     (NUM_SRC),
        .PTR_W (IDX_W)
    ) u_rr_arbiter (
        .req   (eligible),
        .ptr   (rr_ptr_reg),
        .grant (rr_grant)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rr_grant[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    // ready implies eligible implies valid, so any ready bit is a transfer
    assign xfer      = |src_ready;
    assign xfer_idx  = (state_reg == ARB_LOCKED) ? owner_reg : win_idx;
    assign xfer_tail = src_tail[xfer_idx];
    assign xfer_vc   = vc_arr[xfer_idx];

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ARB_IDLE;
            owner_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        if (xfer) begin
            if (xfer_tail) begin
                state_next  = ARB_IDLE;
                rr_ptr_next = (xfer_idx == IDX_W'(NUM_SRC - 1)) ? '0 : xfer_idx + IDX_W'(1);
            end else begin
                state_next = ARB_LOCKED;
                owner_next = xfer_idx;
            end
        end
    end

    // FSM: outputs. A locked owner blocks everyone else even while it stalls.
    always_comb begin
        src_ready = '0;
        if (en) begin
            if (state_reg == ARB_IDLE) begin
                src_ready = rr_grant;
            end else if (eligible[owner_reg]) begin
                src_ready[owner_reg] = 1'b1;
            end
        end
    end

    // ---------------- output register ----------------
    logic [FLIT_W-1:0] flit_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_reg <= '0;
        end else if (xfer) begin
            flit_reg <= {1'b1, xfer_tail, dest_arr[xfer_idx], xfer_vc, data_arr[xfer_idx]};
        end else begin
            flit_reg <= '0;
        end
    end

    assign flit_out  = flit_reg;
    assign send_flit = flit_reg[FLIT_W-1];

    // ---------------- credit counters ----------------
    logic               crd_valid;
    logic [VC_BITS-1:0] crd_vc;
    logic [NUM_VCS-1:0] vc_dec;
    logic [NUM_VCS-1:0] vc_inc;
    logic [NUM_VCS-1:0] vc_over;
    logic               credit_err_reg;

    assign crd_valid = credit_in[VC_BITS];
    assign crd_vc    = credit_in[VC_BITS-1:0];

    for (genvar gi = 0; gi < NUM_VCS; gi++) begin : g_vc
        assign vc_dec[gi]  = xfer && (xfer_vc == VC_BITS'(gi));
        assign vc_inc[gi]  = crd_valid && (crd_vc == VC_BITS'(gi));
        // a simultaneous send and return cancel out, so only a lone return
        // can push the count past the buffer depth
        assign vc_over[gi] = vc_inc[gi] && !vc_dec[gi] && (credit_cnt_reg[gi] == CNT_MAX);
        assign credit_cnt_next[gi] =
            (vc_inc[gi] && !vc_dec[gi] && !vc_over[gi]) ? credit_cnt_reg[gi] + CNT_W'(1) :
            (vc_dec[gi] && !vc_inc[gi])                 ? credit_cnt_reg[gi] - CNT_W'(1) :
                                                          credit_cnt_reg[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                credit_cnt_reg[v] <= CNT_MAX;
            end
            credit_err_reg <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                credit_cnt_reg[v] <= credit_cnt_next[v];
            end
            credit_err_reg <= credit_err_reg | (|vc_over);
        end
    end

    assign credit_err = credit_err_reg;

`ifdef PE_INJECT_STATS_EN
    // ---------------- statistics ----------------
    logic [31:0] flit_cnt_reg [NUM_SRC];
    logic [31:0] stall_cnt_reg;
    logic        owner_stall;

    assign owner_stall = (state_reg == ARB_LOCKED) && src_valid[owner_reg]
                         && (credit_cnt_reg[vc_arr[owner_reg]] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                flit_cnt_reg[i] <= '0;
            end
            stall_cnt_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_ready[i]) begin
                    flit_cnt_reg[i] <= flit_cnt_reg[i] + 32'd1;
                end
            end
            if (owner_stall) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign stat_flits  = flit_cnt_reg[stat_sel];
    assign stat_stalls = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pe_inject_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pe_inject_arbiter
// Directed bench for pe_inject_arbiter with default parameters
// (4 sources, 2 VCs, depth 8, 32-bit data, 2-bit dest, 1-bit VC).
// Inputs change 1 ns after the rising edge; src_ready is sampled 4 ns after
// the edge and registered outputs 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_pe_inject_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [3:0]   src_valid;
    logic [3:0]   src_tail;
    logic [7:0]   src_dest;
    logic [3:0]   src_vc;
    logic [127:0] src_data;
    logic [3:0]   src_ready;
    logic [36:0]  flit_out;
    logic         send_flit;
    logic [1:0]   credit_in;
    logic         credit_err;
`ifdef PE_INJECT_STATS_EN
    logic [1:0]   stat_sel;
    logic [31:0]  stat_flits;
    logic [31:0]  stat_stalls;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_inject_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .src_valid  (src_valid),
        .src_tail   (src_tail),
        .src_dest   (src_dest),
        .src_vc     (src_vc),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .flit_out   (flit_out),
        .send_flit  (send_flit),
        .credit_in  (credit_in),
        .credit_err (credit_err)
`ifdef PE_INJECT_STATS_EN
        ,
        .stat_sel    (stat_sel),
        .stat_flits  (stat_flits),
        .stat_stalls (stat_stalls)
`endif
    );

    function automatic logic [36:0] exp_flit(input logic tail, input logic [1:0] dest,
                                             input logic vc, input logic [31:0] data);
        return {1'b1, tail, dest, vc, data};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic set_src(input int i, input logic v, input logic t, input logic [1:0] d,
                           input logic vc, input logic [31:0] data);
        src_valid[i]         = v;
        src_tail[i]          = t;
        src_dest[i*2 +: 2]   = d;
        src_vc[i]            = vc;
        src_data[i*32 +: 32] = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic do_reset();
        en        = 1'b1;
        src_valid = '0;
        src_tail  = '0;
        src_dest  = '0;
        src_vc    = '0;
        src_data  = '0;
        credit_in = '0;
`ifdef PE_INJECT_STATS_EN
        stat_sel  = '0;
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // ---------- reset state ----------
        do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_flit", flit_out, 37'd0);
        chk("rst_send", send_flit, 1'b0);
        chk("rst_err", credit_err, 1'b0);
        chk("rst_ready", src_ready, 4'b0000);
        chk("rst_crd0", dut.credit_cnt_reg[0], 4'd8);
        chk("rst_crd1", dut.credit_cnt_reg[1], 4'd8);
        chk("rst_ptr", dut.rr_ptr_reg, 2'd0);
`ifdef PE_INJECT_STATS_EN
        chk("rst_stalls", stat_stalls, 32'd0);
`endif
        tick();
        rst_n = 1'b1;

        // ---------- single flit, one-cycle latency ----------
        set_src(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'hA);
        mid();
        chk("s1_ready", src_ready, 4'b0001);
        tick();
        chk("s1_flit", flit_out, exp_flit(1'b1, 2'd2, 1'b0, 32'hA));
        chk("s1_send", send_flit, 1'b1);
        chk("s1_crd0", dut.credit_cnt_reg[0], 4'd7);
        set_src(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
        tick();
        chk("s1_idle_flit", flit_out, 37'd0);
        chk("s1_idle_send", send_flit, 1'b0);

        // ---------- round robin with single-flit packets ----------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_src(i, 1'b1, 1'b1, 2'(i), 1'b0, 32'h10 + 32'(i));
        end
        for (int k = 0; k < 5; k++) begin
            mid();
            chk("rr_ready", src_ready, 4'b0001 << (k % 4));
            tick();
            chk("rr_flit", flit_out, exp_flit(1'b1, 2'(k % 4), 1'b0, 32'h10 + 32'(k % 4)));
            chk("rr_send", send_flit, 1'b1);
        end
        src_valid = '0;
        chk("rr_crd0", dut.credit_cnt_reg[0], 4'd3);
        chk("rr_ptr", dut.rr_ptr_reg, 2'd1);
        tick();
        chk("rr_stop_send", send_flit, 1'b0);

        // ---------- packet atomicity ----------
        do_reset();
        set_src(1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h21);
        set_src(2, 1'b1, 1'b1, 2'd2, 1'b1, 32'h30);
        mid();
        chk("pk_ready_h", src_ready, 4'b0010);
        tick();
        chk("pk_flit_h", flit_out, exp_flit(1'b0, 2'd1, 1'b1, 32'h21));
        src_valid[1] = 1'b0;
        mid();
        chk("pk_ready_gap", src_ready, 4'b0000);
        tick();
        chk("pk_flit_gap", flit_out, 37'd0);
        set_src(1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h22);
        mid();
        chk("pk_ready_b", src_ready, 4'b0010);
        tick();
        chk("pk_flit_b", flit_out, exp_flit(1'b0, 2'd1, 1'b1, 32'h22));
        set_src(1, 1'b1, 1'b1, 2'd1, 1'b1, 32'h23);
        mid();
        chk("pk_ready_t", src_ready, 4'b0010);
        tick();
        chk("pk_flit_t", flit_out, exp_flit(1'b1, 2'd1, 1'b1, 32'h23));
        chk("pk_ptr", dut.rr_ptr_reg, 2'd2);
        src_valid[1] = 1'b0;
        mid();
        chk("pk_ready_s2", src_ready, 4'b0100);
        tick();
        chk("pk_flit_s2", flit_out, exp_flit(1'b1, 2'd2, 1'b1, 32'h30));
        chk("pk_crd1", dut.credit_cnt_reg[1], 4'd4);
        src_valid = '0;

        // ---------- credit stall while locked ----------
        do_reset();
        set_src(1, 1'b1, 1'b1, 2'd0, 1'b1, 32'h55);
        for (int k = 0; k < 8; k++) begin
            set_src(0, 1'b1, 1'b0, 2'd3, 1'b0, 32'(k));
            tick();
        end
        chk("st_flit_last", flit_out, exp_flit(1'b0, 2'd3, 1'b0, 32'd7));
        chk("st_crd0_zero", dut.credit_cnt_reg[0], 4'd0);
        mid();
        chk("st_ready_1", src_ready, 4'b0000);
        tick();
        chk("st_flit_1", flit_out, 37'd0);
        mid();
        chk("st_ready_2", src_ready, 4'b0000);
        tick();
        credit_in = 2'b10;
        mid();
        chk("st_ready_3", src_ready, 4'b0000);
        tick();
        credit_in = 2'b00;
        chk("st_crd0_one", dut.credit_cnt_reg[0], 4'd1);
`ifdef PE_INJECT_STATS_EN
        chk("st_stalls", stat_stalls, 32'd3);
`endif
        set_src(0, 1'b1, 1'b1, 2'd3, 1'b0, 32'h99);
        mid();
        chk("st_ready_go", src_ready, 4'b0001);
        tick();
        chk("st_flit_go", flit_out, exp_flit(1'b1, 2'd3, 1'b0, 32'h99));
        chk("st_crd0_end", dut.credit_cnt_reg[0], 4'd0);
`ifdef PE_INJECT_STATS_EN
        stat_sel = 2'd0;
        #1;
        chk("st_flits0", stat_flits, 32'd9);
`endif
        src_valid[0] = 1'b0;
        mid();
        chk("st_ready_s1", src_ready, 4'b0010);
        tick();
        src_valid = '0;

        // ---------- simultaneous send/return and overflow ----------
        do_reset();
        set_src(2, 1'b1, 1'b1, 2'd1, 1'b1, 32'h66);
        credit_in = 2'b11;
        mid();
        chk("cr_ready", src_ready, 4'b0100);
        tick();
        credit_in = 2'b00;
        src_valid = '0;
        chk("cr_flit", flit_out, exp_flit(1'b1, 2'd1, 1'b1, 32'h66));
        chk("cr_crd1_same", dut.credit_cnt_reg[1], 4'd8);
        chk("cr_err_none", credit_err, 1'b0);
        credit_in = 2'b11;
        tick();
        credit_in = 2'b00;
        chk("cr_crd1_max", dut.credit_cnt_reg[1], 4'd8);
        chk("cr_err_set", credit_err, 1'b1);
        tick();
        chk("cr_err_sticky", credit_err, 1'b1);

        // ---------- enable low ----------
        do_reset();
        chk("en_err_clr", credit_err, 1'b0);
        set_src(1, 1'b1, 1'b1, 2'd2, 1'b1, 32'h80);
        set_src(0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h70);
        tick();
        set_src(0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h71);
        tick();
        chk("en_flit_pre", flit_out, exp_flit(1'b0, 2'd0, 1'b0, 32'h71));
        chk("en_crd0_pre", dut.credit_cnt_reg[0], 4'd6);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            credit_in = (k < 2) ? 2'b10 : 2'b00;
            mid();
            chk("en_ready_off", src_ready, 4'b0000);
            tick();
            chk("en_flit_off", flit_out, 37'd0);
        end
        credit_in = 2'b00;
        chk("en_crd0_back", dut.credit_cnt_reg[0], 4'd8);
        en = 1'b1;
        set_src(0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h72);
        mid();
        chk("en_ready_own", src_ready, 4'b0001);
        tick();
        chk("en_flit_tail", flit_out, exp_flit(1'b1, 2'd0, 1'b0, 32'h72));
        chk("en_crd0_post", dut.credit_cnt_reg[0], 4'd7);
        src_valid[0] = 1'b0;
        mid();
        chk("en_ready_s1", src_ready, 4'b0010);
        tick();
        chk("en_flit_s1", flit_out, exp_flit(1'b1, 2'd2, 1'b1, 32'h80));
        src_valid = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
